spi_word_fifo_rx: RTL

SPI_WORD_FIFO_RX -- requirements
Module: spi_word_fifo_rx

---
 rtl/spi_word_fifo_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_word_fifo_rx.sv
// SPI receive-only slave that assembles WIDTH-bit words and queues them in a
// first-word-fall-through FIFO for a clk-domain consumer.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   nCS, SCK, MOSI    SPI slave inputs, asynchronous to clk
//   data_o, valid_o   FIFO head word and not-empty flag
//   ready_i           consumer pops the head when valid_o && ready_i
//   level_o           FIFO occupancy (0..DEPTH)
//   overflow_o        sticky: a completed word was dropped because the FIFO was full
//   frame_err_o       one-cycle pulse: nCS rose with a partial word in flight
//   clr_i             synchronous clear of overflow_o
module spi_word_fifo_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter bit          SAMPLE_RISE = 1'b1,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nCS,
  input  logic                       SCK,
  input  logic                       MOSI,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       overflow_o,
  output logic                       frame_err_o,
  input  logic                       clr_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  // SCK idles at the level opposite the sampling edge, so reset matches idle.
  localparam logic SckRst = SAMPLE_RISE ? 1'b0 : 1'b1;

  // Two-flop synchronisers plus one extra SCK stage for edge detection.
  logic ncs_meta_q, ncs_sync_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_meta_q  <= 1'b1;
      ncs_sync_q  <= 1'b1;
      sck_meta_q  <= SckRst;
      sck_sync_q  <= SckRst;
      sck_prev_q  <= SckRst;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      ncs_meta_q  <= nCS;
      ncs_sync_q  <= ncs_meta_q;
      sck_meta_q  <= SCK;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // Receiver: shift register and bit counter.
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             sample_edge;
  logic             push;

  always_comb begin
    if (SAMPLE_RISE) sample_edge = ~ncs_sync_q & sck_sync_q & ~sck_prev_q;
    else             sample_edge = ~ncs_sync_q & ~sck_sync_q & sck_prev_q;
  end

  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (ncs_sync_q) begin
      // Partial word is abandoned; the counter going to 0 keeps the pulse one cycle.
      cnt_d       = '0;
      frame_err_d = (cnt_q != '0);
    end else if (sample_edge) begin
      if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], mosi_sync_q};
      else           shift_d = {mosi_sync_q, shift_q[WIDTH-1:1]};
      if (cnt_q == CW'(WIDTH - 1)) begin
        cnt_d = '0;
        push  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO. The completed word (shift_d) is written at the end of the detect cycle,
  // so it is visible on data_o the following cycle.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             pop, full, wr_en;

  assign pop   = valid_o & ready_i;
  assign full  = (level_q == LW'(DEPTH));
  // When full, a same-cycle pop frees the slot the push needs.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !pop)      level_d = level_q + LW'(1);
    else if (!wr_en && pop) level_d = level_q - LW'(1);
    // A new drop wins over a coincident clear.
    if (push && full && !pop) overflow_d = 1'b1;
    else if (clr_i)           overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_d;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign valid_o     = (level_q != '0);
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule
